// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: oversampling edge/bit timing engine for the UART receiver.
// Counts PRESCALE clock-enable edges per bit and a configurable number of bits
// per frame, and majority-votes three samples taken around mid-bit.
//
// Handshake note: this block has no valid/ready pair. SAMPLE_VALID, BIT_DONE and
// FRAME_DONE are single-cycle registered strobes that the consumers must take in
// the cycle they are high; there is no back-pressure. START is a request that is
// only honoured in IDLE, and COUNT_CLR overrides everything except RST.
// The FSM has two states, so BUSY is a direct copy of the state register and
// serves as its debug view.
module uart_rx_bit_timer #(
  parameter int PS_W       = 6,
  parameter int DATA_WIDTH = 8,
  parameter int BC_W       = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            START,
  input  logic            COUNT_CLR,
  input  logic [PS_W-1:0] PRESCALE,
  input  logic            PAR_EN,
  input  logic            STOP2,
  input  logic            RX_IN,
  output logic [PS_W-1:0] EDGE_COUNT,
  output logic [BC_W-1:0] BIT_COUNT,
  output logic            SAMPLED_BIT,
  output logic            SAMPLE_VALID,
  output logic            BIT_DONE,
  output logic            FRAME_DONE,
  output logic            BUSY,
  output logic            PS_ERR
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  localparam logic [PS_W-1:0] PS_MIN   = PS_W'(4);
  localparam logic [BC_W-1:0] FLEN_BASE = BC_W'(2 + DATA_WIDTH);

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [BC_W-1:0] flen_q, flen_d;   // frame length; encodes latched PAR_EN/STOP2
  logic [PS_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic            s0_q, s0_d;
  logic            s1_q, s1_d;
  logic            sampled_bit_q, sampled_bit_d;
  logic            sample_valid_q, sample_valid_d;
  logic            bit_done_q, bit_done_d;
  logic            frame_done_q, frame_done_d;
  logic            ps_err_q, ps_err_d;

  logic [PS_W-1:0] mid, mid_m1, mid_p1, last_edge;
  logic [BC_W-1:0] last_bit;
  logic            at_last_edge, at_last_bit, vote;

  assign mid          = ps_q >> 1;
  assign mid_m1       = mid - PS_W'(1);
  assign mid_p1       = mid + PS_W'(1);
  assign last_edge    = ps_q - PS_W'(1);
  assign last_bit     = flen_q - BC_W'(1);
  assign at_last_edge = (edge_cnt_q == last_edge);
  assign at_last_bit  = (bit_cnt_q == last_bit);
  assign vote         = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);

  // State and datapath registers, asynchronously cleared by RST.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      ps_q           <= '0;
      flen_q         <= '0;
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      bit_done_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      ps_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ps_q           <= ps_d;
      flen_q         <= flen_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      bit_done_q     <= bit_done_d;
      frame_done_q   <= frame_done_d;
      ps_err_q       <= ps_err_d;
    end
  end

  // Next-state logic: START with a legal prescale enters ACTIVE, last edge of last bit exits.
  always_comb begin
    state_d = state_q;
    if (COUNT_CLR) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (START && (PRESCALE >= PS_MIN)) state_d = ACTIVE;
        ACTIVE:  if (EN && at_last_edge && at_last_bit) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: config latch, edge/bit counters, mid-bit sampling and strobes.
  always_comb begin
    ps_d           = ps_q;
    flen_d         = flen_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    s0_d           = s0_q;
    s1_d           = s1_q;
    sampled_bit_d  = sampled_bit_q;
    ps_err_d       = ps_err_q;
    sample_valid_d = 1'b0;
    bit_done_d     = 1'b0;
    frame_done_d   = 1'b0;
    if (COUNT_CLR) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      s0_d       = 1'b0;
      s1_d       = 1'b0;
      ps_err_d   = 1'b0;
    end else if (state_q == IDLE) begin
      if (START) begin
        if (PRESCALE >= PS_MIN) begin
          ps_d       = PRESCALE;
          flen_d     = FLEN_BASE + BC_W'(PAR_EN) + BC_W'(STOP2);
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
          ps_err_d   = 1'b0;
        end else begin
          ps_err_d = 1'b1;
        end
      end
    end else if (EN) begin
      // The three sample points never overlap; the vote point may coincide with the wrap (PS=4).
      if (edge_cnt_q == mid_m1) s0_d = RX_IN;
      if (edge_cnt_q == mid)    s1_d = RX_IN;
      if (edge_cnt_q == mid_p1) begin
        sampled_bit_d  = vote;
        sample_valid_d = 1'b1;
      end
      if (at_last_edge) begin
        edge_cnt_d = '0;
        bit_done_d = 1'b1;
        if (at_last_bit) begin
          bit_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end else begin
        edge_cnt_d = edge_cnt_q + PS_W'(1);
      end
    end
  end

  // Output mapping: every output comes straight from a register.
  always_comb begin
    EDGE_COUNT   = edge_cnt_q;
    BIT_COUNT    = bit_cnt_q;
    SAMPLED_BIT  = sampled_bit_q;
    SAMPLE_VALID = sample_valid_q;
    BIT_DONE     = bit_done_q;
    FRAME_DONE   = frame_done_q;
    BUSY         = (state_q == ACTIVE);
    PS_ERR       = ps_err_q;
  end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb_uart_rx_bit_timer: directed frames with a pulse scoreboard. The driver
// pushes each expected strobe event (cycle stamp, SAMPLE_VALID, voted bit,
// BIT_DONE, FRAME_DONE) into exp_q; a negedge monitor pops and compares.
module tb_uart_rx_bit_timer;

  localparam int PS_W = 6;
  localparam int DW   = 8;
  localparam int BC_W = 5;
  localparam int EW   = 24;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            EN = 1'b0;
  logic            START = 1'b0;
  logic            COUNT_CLR = 1'b0;
  logic [PS_W-1:0] PRESCALE = '0;
  logic            PAR_EN = 1'b0;
  logic            STOP2 = 1'b0;
  logic            RX_IN = 1'b1;
  logic [PS_W-1:0] EDGE_COUNT;
  logic [BC_W-1:0] BIT_COUNT;
  logic            SAMPLED_BIT, SAMPLE_VALID, BIT_DONE, FRAME_DONE, BUSY, PS_ERR;

  uart_rx_bit_timer #(.PS_W(PS_W), .DATA_WIDTH(DW), .BC_W(BC_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .COUNT_CLR(COUNT_CLR),
    .PRESCALE(PRESCALE), .PAR_EN(PAR_EN), .STOP2(STOP2), .RX_IN(RX_IN),
    .EDGE_COUNT(EDGE_COUNT), .BIT_COUNT(BIT_COUNT), .SAMPLED_BIT(SAMPLED_BIT),
    .SAMPLE_VALID(SAMPLE_VALID), .BIT_DONE(BIT_DONE), .FRAME_DONE(FRAME_DONE),
    .BUSY(BUSY), .PS_ERR(PS_ERR)
  );

  // ---------------- clock / cycle stamp ----------------
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] mk(input int unsigned t, input logic sv, input logic sb,
                                       input logic bd, input logic fd);
    return {t[19:0], sv, sb & sv, bd, fd};
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    logic [EW-1:0] act, e;
    if (SAMPLE_VALID || BIT_DONE || FRAME_DONE) begin
      act = mk(cyc, SAMPLE_VALID, SAMPLED_BIT, BIT_DONE, FRAME_DONE);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_unexpected: got t=%0d sv/sb/bd/fd=%b with nothing expected",
                 act[23:4], act[3:0]);
      end else begin
        e = exp_q.pop_front();
        if (e !== act) begin
          n_fail++;
          $display("FAIL pulse: got t=%0d sv/sb/bd/fd=%b expected t=%0d sv/sb/bd/fd=%b",
                   act[23:4], act[3:0], e[23:4], e[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_edge"}, EDGE_COUNT, 0);
    check({tag, "_bit"}, BIT_COUNT, 0);
    check({tag, "_sampled"}, SAMPLED_BIT, 0);
    check({tag, "_sv"}, SAMPLE_VALID, 0);
    check({tag, "_bd"}, BIT_DONE, 0);
    check({tag, "_fd"}, FRAME_DONE, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_ps_err"}, PS_ERR, 0);
  endtask

  // Runs one frame: EN high once every 'period' cycles; RX_IN = base_rx except the
  // three sample edges of bit pat_bit, which get pat[2], pat[1], pat[0].
  // n_stop > 0 stops after that many EN edges; alt_ps != 0 changes PRESCALE mid-frame.
  task automatic run_frame(input int ps, input int par, input int st2, input int period,
                           input logic base_rx, input int pat_bit, input logic [2:0] pat,
                           input int n_stop, input int alt_ps);
    int flen, mid, total, last_n, k, e, b, ns, nd;
    int unsigned t0;
    logic sb;
    flen   = 2 + DW + par + st2;
    mid    = ps / 2;
    total  = flen * ps;
    last_n = (n_stop == 0 || n_stop > total) ? total : n_stop;
    PRESCALE = PS_W'(ps);
    PAR_EN   = par[0];
    STOP2    = st2[0];
    RX_IN    = base_rx;
    EN       = (period == 1);
    START    = 1'b1;
    tick();
    START = 1'b0;
    t0 = cyc;
    check("busy_after_start", BUSY, 1);
    check("ps_err_after_start", PS_ERR, 0);
    check("edge_after_start", EDGE_COUNT, 0);
    check("bit_after_start", BIT_COUNT, 0);
    for (int bb = 0; bb < flen; bb++) begin
      ns = bb * ps + mid + 2;
      nd = (bb + 1) * ps;
      sb = (bb == pat_bit) ? maj3(pat) : base_rx;
      if (ns == nd) begin
        if (nd <= last_n) exp_q.push_back(mk(t0 + period * nd, 1'b1, sb, 1'b1, bb == flen - 1));
      end else begin
        if (ns <= last_n) exp_q.push_back(mk(t0 + period * ns, 1'b1, sb, 1'b0, 1'b0));
        if (nd <= last_n) exp_q.push_back(mk(t0 + period * nd, 1'b0, 1'b0, 1'b1, bb == flen - 1));
      end
    end
    k = 0;
    for (int n = 1; n <= last_n; n++) begin
      e = (n - 1) % ps;
      b = (n - 1) / ps;
      for (int c = 1; c <= period; c++) begin
        EN = (c == period);
        if (b == pat_bit && e == mid - 1)      RX_IN = pat[2];
        else if (b == pat_bit && e == mid)     RX_IN = pat[1];
        else if (b == pat_bit && e == mid + 1) RX_IN = pat[0];
        else                                   RX_IN = base_rx;
        if (alt_ps != 0 && n == 2 * ps + 1) PRESCALE = PS_W'(alt_ps);
        tick();
        if (c == period) k++;
        check("edge_count", EDGE_COUNT, k % ps);
        check("bit_count", BIT_COUNT, (k / ps) % flen);
      end
    end
    EN = 1'b0;
    if (last_n == total) check("busy_after_frame", BUSY, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    RST = 1'b1;
    tick();

    // PS=16, 8N1: bit done every 16 clocks, frame done 160 clocks after START.
    run_frame(16, 0, 0, 1, 1'b1, -1, 3'b000, 0, 0);
    tick();

    // PS=8 majority votes: 1,0,1 on a low line -> 1; 0,1,0 on a high line -> 0.
    run_frame(8, 0, 0, 1, 1'b0, 2, 3'b101, 0, 0);
    tick();
    run_frame(8, 0, 0, 1, 1'b1, 2, 3'b010, 0, 0);
    tick();

    // PS=5 with parity and two stop bits, EN every third clock: FLEN=12, 60 EN edges.
    run_frame(5, 1, 1, 3, 1'b1, -1, 3'b000, 0, 0);
    tick();

    // Illegal prescale latches PS_ERR, COUNT_CLR clears it, a legal START clears it too.
    PRESCALE = PS_W'(3);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("ps3_ps_err", PS_ERR, 1);
    check("ps3_busy", BUSY, 0);
    check("ps3_edge", EDGE_COUNT, 0);
    check("ps3_bit", BIT_COUNT, 0);
    tick();
    check("ps_err_holds", PS_ERR, 1);
    COUNT_CLR = 1'b1;
    tick();
    COUNT_CLR = 1'b0;
    check("ps_err_clr", PS_ERR, 0);
    PRESCALE = PS_W'(2);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("ps2_ps_err", PS_ERR, 1);
    // PS=4: samples at edges 1,2,3; vote lands on the wrap edge together with BIT_DONE.
    run_frame(4, 0, 0, 1, 1'b0, 1, 3'b101, 0, 0);
    tick();

    // COUNT_CLR with START at bit 4 / edge 7 (PS=8): everything clears, START ignored.
    run_frame(8, 0, 0, 1, 1'b1, -1, 3'b000, 39, 0);
    check("pre_clr_edge", EDGE_COUNT, 7);
    check("pre_clr_bit", BIT_COUNT, 4);
    COUNT_CLR = 1'b1;
    START = 1'b1;
    EN = 1'b1;
    PRESCALE = PS_W'(8);
    tick();
    COUNT_CLR = 1'b0;
    START = 1'b0;
    EN = 1'b0;
    check("clr_edge", EDGE_COUNT, 0);
    check("clr_bit", BIT_COUNT, 0);
    check("clr_busy", BUSY, 0);
    check("clr_bd", BIT_DONE, 0);
    check("clr_sv", SAMPLE_VALID, 0);
    check("clr_fd", FRAME_DONE, 0);
    check("clr_sampled_held", SAMPLED_BIT, 1);
    tick();
    check("clr_stays_idle", BUSY, 0);

    // PRESCALE 16->8 mid-frame is ignored; RST at bit 6 clears everything at once.
    run_frame(16, 0, 0, 1, 1'b1, -1, 3'b000, 98, 8);
    check("pre_rst_bit", BIT_COUNT, 6);
    check("pre_rst_sampled", SAMPLED_BIT, 1);
    RST = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    RST = 1'b1;
    tick();
    check("post_rst_busy", BUSY, 0);

    repeat (3) tick();
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_timer.md
Name: uart_rx_bit_timer

Overview:
Parametrised edge/bit timing engine for the UART receiver. It replaces the fixed 8/16/32 oversampling counter with one that supports any prescale from 4 to 2^PS_W-1 and frames with configurable data, parity and stop bits. It also performs 3-sample majority voting around mid-bit. It sits between the RX FSM, which issues START and COUNT_CLR, and the deserializer/parity/stop checkers, which consume SAMPLED_BIT, SAMPLE_VALID, BIT_DONE and FRAME_DONE.

Parameters:
PS_W, 6, width of PRESCALE and EDGE_COUNT; max prescale 2^PS_W-1.
DATA_WIDTH, 8, data bits per frame (1..16).
BC_W, 5, width of BIT_COUNT; must hold DATA_WIDTH+3.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
EN  in  1  count enable; state frozen when low
START  in  1  begin frame timing (honoured in IDLE only)
COUNT_CLR  in  1  synchronous active-high abort/clear, highest priority after RST
PRESCALE  in  PS_W  oversampling ratio, latched at START
PAR_EN  in  1  parity bit present, latched at START
STOP2  in  1  two stop bits, latched at START
RX_IN  in  1  synchronised serial input
EDGE_COUNT  out  PS_W  oversample edge index within current bit
BIT_COUNT  out  BC_W  bit index within frame (0 = start bit)
SAMPLED_BIT  out  1  majority-voted value of last bit
SAMPLE_VALID  out  1  one-CLK pulse: SAMPLED_BIT updated
BIT_DONE  out  1  one-CLK pulse: bit period ended
FRAME_DONE  out  1  one-CLK pulse: last bit period ended
BUSY  out  1  high in ACTIVE
PS_ERR  out  1  latched PRESCALE < 4 at START

Behaviour:
- Reset: all outputs 0, state IDLE, latched config 0.
- States IDLE, ACTIVE. The pulse outputs (SAMPLE_VALID, BIT_DONE, FRAME_DONE) are registered and deasserted in every cycle not explicitly named below.
- IDLE + START (EN is don't-care):
  - if PRESCALE >= 4: latch PRESCALE as PS, latch PAR_EN and STOP2, set FLEN = 2 + DATA_WIDTH + PAR_EN + STOP2, clear counters, clear PS_ERR, go ACTIVE.
  - if PRESCALE < 4: set PS_ERR=1 and stay in IDLE. PS_ERR holds until the next START or COUNT_CLR.
- ACTIVE, EN=1:
  - EDGE_COUNT increments.
  - When EDGE_COUNT == PS-1: EDGE_COUNT goes to 0 and BIT_DONE pulses next cycle.
  - If also BIT_COUNT == FLEN-1: BIT_COUNT goes to 0, FRAME_DONE pulses together with BIT_DONE, and state goes to IDLE.
  - Otherwise BIT_COUNT increments.
- ACTIVE, EN=0: counters, sample register and state hold.
- Sampling: MID = PS>>1 (floor).
  - On EN cycles with EDGE_COUNT equal to MID-1 or MID, capture RX_IN into s0 and s1 respectively.
  - On the EN cycle with EDGE_COUNT == MID+1: SAMPLED_BIT <= majority(s0, s1, RX_IN) and SAMPLE_VALID pulses on the same registered edge.
  - SAMPLED_BIT holds between updates.
  - With PS=4, samples fall at edges 1, 2, 3. The last one coincides with the wrap edge; both actions occur.
- START while ACTIVE is ignored. PRESCALE, PAR_EN and STOP2 changes mid-frame have no effect.
- COUNT_CLR=1 (any state, any EN): counters 0, pulses 0, s0/s1 0, PS_ERR 0, state IDLE. SAMPLED_BIT is held. START in the same cycle is ignored.
- RST mid-frame: immediate return to reset values.
- EDGE_COUNT never reaches PS; BIT_COUNT never reaches FLEN. No wrap beyond these bounds.
- Odd prescale is legal; MID is floor, e.g. PS=5 samples at edges 1, 2, 3.

Test Plan:
- PS=16, DATA_WIDTH=8, PAR_EN=0, STOP2=0, EN constant 1, START -> FLEN=10, BIT_DONE every 16 CLK, FRAME_DONE once 160 CLK after START, BUSY low after.
- PS=8, RX_IN pattern 1,0,1 at edges 3,4,5 of bit 2 -> SAMPLED_BIT=1 with SAMPLE_VALID pulse; pattern 0,1,0 -> SAMPLED_BIT=0.
- PS=5, PAR_EN=1, STOP2=1, EN high every 3rd CLK -> EDGE_COUNT cycles 0..4, FLEN=12, FRAME_DONE after 60 EN pulses; counts frozen between EN pulses.
- START with PRESCALE=3 -> PS_ERR=1, BUSY=0, counters 0. Next START with PRESCALE=4 -> PS_ERR=0, ACTIVE, samples at edges 1, 2, 3.
- COUNT_CLR asserted at BIT_COUNT=4, EDGE_COUNT=7 with START also high -> next cycle all counters 0, IDLE, no pulses.
- PRESCALE changed 16->8 mid-frame, and RST pulsed low at BIT_COUNT=6 -> timing stays at 16 until RST; after RST all outputs 0.
